// File: rtl/spi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// spi_tx_arbiter
//
// Shares one SPI controller TX byte port between NUM_REQ requesters.
// Round-robin arbitration. An owner keeps the grant across a multi-byte
// transfer until it presents a byte flagged last. Each byte is sent as a
// one-cycle DV pulse. The arbiter then follows the controller's ready profile
// (ready drops while busy and rises when done) and acks the owner.
//
// Optional feature (macro SPI_TX_ARB_STATS_EN):
//   adds o_Byte_Cnt, one wrapping CNT_W-bit sent-byte counter per requester.
//   Without the macro the port and the counters are absent.
//
// Ports
//   i_Clk        system clock
//   i_Rst        synchronous reset, active-high
//   i_Req_DV     [NUM_REQ]   request valid, held until ack
//   i_Req_Byte   [8*NUM_REQ] byte of requester k at [8k+7:8k]
//   i_Req_Last   [NUM_REQ]   presented byte ends the transfer
//   o_Req_Ack    [NUM_REQ]   one-cycle pulse, byte shifted out
//   o_Grant      [NUM_REQ]   one-hot owner, 0 when idle
//   o_Grant_Idx  [IDX_W]     owner index, valid while o_Grant != 0
//   o_TX_Byte    [8]         byte to controller
//   o_TX_DV                  one-cycle data valid to controller
//   i_TX_Ready               controller ready for next byte
//   o_Busy                   FSM not idle
//   o_Byte_Cnt   [CNT_W*NUM_REQ] per-requester counts (stats build only)
// ---------------------------------------------------------------------------

`ifdef SPI_TX_ARB_STATS_EN
// Per-requester sent-byte counter. Wraps naturally at 2^CNT_W.
module spi_tx_arb_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Inc,
    output logic [CNT_W-1:0] o_Cnt
);
    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            o_Cnt <= '0;
        else if (i_Inc)
            o_Cnt <= o_Cnt + 1'b1;
    end
endmodule
`endif

module spi_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic [NUM_REQ-1:0]       i_Req_DV,
    input  logic [8*NUM_REQ-1:0]     i_Req_Byte,
    input  logic [NUM_REQ-1:0]       i_Req_Last,
    output logic [NUM_REQ-1:0]       o_Req_Ack,
    output logic [NUM_REQ-1:0]       o_Grant,
    output logic [IDX_W-1:0]         o_Grant_Idx,
    output logic [7:0]               o_TX_Byte,
    output logic                     o_TX_DV,
    input  logic                     i_TX_Ready,
    output logic                     o_Busy
`ifdef SPI_TX_ARB_STATS_EN
    ,
    output logic [CNT_W*NUM_REQ-1:0] o_Byte_Cnt
`endif
);

    // Stop elaboration on a parameter set the index arithmetic cannot serve.
    if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ) || CNT_W < 1) begin : g_bad_cfg
        $error("spi_tx_arbiter: unsupported NUM_REQ/IDX_W/CNT_W");
    end

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_n;
    logic                 last_q, last_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic [IDX_W-1:0]     idx_n;
    logic [7:0]           byte_n;
    logic                 dv_n;
    logic [NUM_REQ-1:0]   ack_n;
    logic [NUM_REQ-1:0]   req_eff;
    logic [IDX_W:0]       pick;      // {found, index}
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;

    // A requester still shows its old DV during the ack cycle, because it
    // only reacts from the following cycle on. Masking the acked bit stops
    // the byte that was just sent from being latched a second time.
    assign req_eff = i_Req_DV & ~o_Req_Ack;

    // First requesting index at or after ptr, wrapping at NUM_REQ.
    // Scanning from the far end lets the nearest hit overwrite the result.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] pos;
        rr_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQ))
                pos = pos - (IDX_W+1)'(NUM_REQ);
            if (req[pos[IDX_W-1:0]])
                rr_pick = {1'b1, pos[IDX_W-1:0]};
        end
    endfunction

    assign pick     = rr_pick(req_eff, rr_ptr);
    assign pick_vld = pick[IDX_W];
    assign pick_idx = pick[IDX_W-1:0];

    // Next-state and next-output logic. Every output is registered, so
    // o_TX_DV and o_Req_Ack appear the cycle after their condition.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        last_n   = last_q;
        grant_n  = o_Grant;
        idx_n    = o_Grant_Idx;
        byte_n   = o_TX_Byte;
        dv_n     = 1'b0;
        ack_n    = '0;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_n = NUM_REQ'(1) << pick_idx;
                    idx_n   = pick_idx;
                    byte_n  = i_Req_Byte[{pick_idx, 3'b000} +: 8];
                    last_n  = i_Req_Last[pick_idx];
                    state_n = SEND;
                end
            end

            SEND: begin
                if (i_TX_Ready) begin
                    dv_n    = 1'b1;
                    state_n = WAIT_BUSY;
                end
            end

            // The controller drops ready once it has taken the byte.
            WAIT_BUSY: begin
                if (!i_TX_Ready)
                    state_n = WAIT_DONE;
            end

            // Ready rises again when the byte is shifted out.
            WAIT_DONE: begin
                if (i_TX_Ready) begin
                    ack_n = o_Grant;
                    if (last_q) begin
                        grant_n  = '0;
                        rr_ptr_n = (o_Grant_Idx == IDX_W'(NUM_REQ - 1)) ?
                                   '0 : o_Grant_Idx + 1'b1;
                        state_n  = IDLE;
                    end else begin
                        state_n  = HOLD;
                    end
                end
            end

            // Locked: only the owner can move the FSM.
            HOLD: begin
                if (req_eff[o_Grant_Idx]) begin
                    byte_n  = i_Req_Byte[{o_Grant_Idx, 3'b000} +: 8];
                    last_n  = i_Req_Last[o_Grant_Idx];
                    state_n = SEND;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            last_q      <= 1'b0;
            o_Grant     <= '0;
            o_Grant_Idx <= '0;
            o_TX_Byte   <= '0;
            o_TX_DV     <= 1'b0;
            o_Req_Ack   <= '0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            last_q      <= last_n;
            o_Grant     <= grant_n;
            o_Grant_Idx <= idx_n;
            o_TX_Byte   <= byte_n;
            o_TX_DV     <= dv_n;
            o_Req_Ack   <= ack_n;
        end
    end

    assign o_Busy = (state != IDLE);

`ifdef SPI_TX_ARB_STATS_EN
    // Counters advance on the same edge that registers the ack. A reset on
    // that edge therefore drops both the ack and the count.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        spi_tx_arb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .i_Clk (i_Clk),
            .i_Rst (i_Rst),
            .i_Inc (ack_n[k]),
            .o_Cnt (o_Byte_Cnt[CNT_W*k +: CNT_W])
        );
    end
`endif

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Bench for spi_tx_arbiter. Requester agents and a controller model drive
// the inputs. A reference model predicts the owner from round-robin rules
// when each grant appears, and queues the owner's transfer bytes. A monitor
// pops that queue on every TX DV and ack.
module tb_spi_tx_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int CW = 16;
  localparam int QD = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]   req_dv = '0;
  logic [NR-1:0]   req_last = '0;
  logic [8*NR-1:0] req_byte = '0;
  logic [NR-1:0]   ack, grant;
  logic [IW-1:0]   grant_idx;
  logic [7:0]      tx_byte;
  logic            tx_dv, tx_ready, busy;
  logic            ctrl_rdy = 1'b1;
  logic            ctrl_force_low = 1'b0;
  assign tx_ready = ctrl_rdy & ~ctrl_force_low;
`ifdef SPI_TX_ARB_STATS_EN
  logic [CW*NR-1:0] byte_cnt;
`endif

  spi_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .CNT_W(CW)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
    .i_Req_Last(req_last), .o_Req_Ack(ack), .o_Grant(grant),
    .o_Grant_Idx(grant_idx), .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv),
    .i_TX_Ready(tx_ready), .o_Busy(busy)
`ifdef SPI_TX_ARB_STATS_EN
    , .o_Byte_Cnt(byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-requester pending bytes {last, byte}. Main pushes, the agent pops on ack.
  logic [8:0] rq_mem [NR][QD];
  int rq_hd [NR] = '{default: 0};
  int rq_tl [NR] = '{default: 0};
  bit hold_in_rst = 1'b0;
  bit rand_en = 1'b0;

  task automatic push_byte(input int k, input logic [7:0] b, input logic l);
    rq_mem[k][rq_tl[k] % QD] = {l, b};
    rq_tl[k]++;
  endtask

  // Reference: the first requester at or after ptr, wrapping; -1 if none.
  function automatic int rr_model(input logic [NR-1:0] req, input int ptr);
    for (int i = 0; i < NR; i++)
      if (req[(ptr + i) % NR]) return (ptr + i) % NR;
    return -1;
  endfunction

  // Requester agents: after an ack, pop the byte and present the next one
  // (after a random gap when rand_en is set).
  task automatic agent_step();
    for (int k = 0; k < NR; k++) begin
      if (req_dv[k] && ack[k]) begin
        rq_hd[k]++;
        req_dv[k] = 1'b0;
      end
      if (!req_dv[k] && rq_hd[k] != rq_tl[k] && (!rand_en || $urandom_range(0, 2) == 0)) begin
        req_dv[k] = 1'b1;
        {req_last[k], req_byte[8*k +: 8]} = rq_mem[k][rq_hd[k] % QD];
      end
    end
  endtask

  // Driver: acts 1 time unit after each negedge.
  initial begin
    int busy_dly, busy_len, stall_len;
    busy_dly = 0; busy_len = 0; stall_len = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        busy_dly = 0; busy_len = 0; stall_len = 0;
        ctrl_rdy = 1'b1;
        if (hold_in_rst) agent_step();
        else for (int k = 0; k < NR; k++) begin
          rq_hd[k] = rq_tl[k];
          req_dv[k] = 1'b0;
        end
      end else begin
        // Controller model: after a DV, ready drops (after 0-2 cycles) for
        // 1-4 cycles. Random short stalls can occur otherwise.
        if (tx_dv) begin
          busy_dly  = rand_en ? $urandom_range(0, 2) : 0;
          busy_len  = rand_en ? $urandom_range(1, 4) : 1;
          stall_len = 0;
        end
        if (busy_dly > 0) begin
          busy_dly--; ctrl_rdy = 1'b1;
        end else if (busy_len > 0) begin
          busy_len--; ctrl_rdy = 1'b0;
        end else if (stall_len > 0) begin
          stall_len--; ctrl_rdy = 1'b0;
        end else begin
          ctrl_rdy = 1'b1;
          if (rand_en && $urandom_range(0, 9) == 0) stall_len = $urandom_range(1, 3);
        end
        agent_step();
      end
    end
  end

  // Scoreboard: {owner, last, byte} per expected TX byte.
  logic [10:0] exp_q [$];
  logic [7:0]  sent_log [$];
  int          cnt_m [NR] = '{default: 0};
  bit          cur_vld = 1'b0;

  // Monitor: samples at each negedge.
  initial begin
    logic [10:0]   cur;
    logic [NR-1:0] prev_grant, prev_ack;
    logic          prev_dv;
    int            ptr_m, w, oi;
    prev_grant = '0; prev_ack = '0; prev_dv = 1'b0; ptr_m = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ack", ack, 0);
        chk("rst_grant", grant, 0);
        chk("rst_txdv", tx_dv, 0);
        chk("rst_txbyte", tx_byte, 0);
        chk("rst_busy", busy, 0);
`ifdef SPI_TX_ARB_STATS_EN
        for (int k = 0; k < NR; k++) chk("rst_cnt", byte_cnt[CW*k +: CW], 0);
`endif
        exp_q.delete();
        cur_vld = 1'b0; ptr_m = 0;
        for (int k = 0; k < NR; k++) cnt_m[k] = 0;
        prev_grant = '0; prev_ack = '0; prev_dv = 1'b0;
      end else begin
        if (grant != 0 && prev_grant == 0) begin
          // This grant was decided from the DV visible now, minus last cycle's ack.
          w = rr_model(req_dv & ~prev_ack, ptr_m);
          if (w < 0) chk("grant_spurious", grant, 0);
          else begin
            chk("grant_onehot", grant, 32'(1) << w);
            chk("grant_idx", grant_idx, w);
            for (int j = rq_hd[w]; j < rq_tl[w]; j++) begin
              exp_q.push_back({IW'(w), rq_mem[w][j % QD]});
              if (rq_mem[w][j % QD][8]) break;
            end
          end
        end else if (grant != prev_grant && grant != 0) begin
          chk("grant_stable", grant, prev_grant);
        end

        if (tx_dv) begin
          chk("dv_single", prev_dv, 0);
          chk("dv_before_ack", cur_vld, 0);
          if (exp_q.size() == 0) chk("dv_unexpected", tx_dv, 0);
          else begin
            cur = exp_q.pop_front();
            cur_vld = 1'b1;
            chk("tx_byte", tx_byte, cur[7:0]);
            chk("tx_owner", grant, 32'(1) << cur[10:9]);
            sent_log.push_back(tx_byte);
          end
        end

        if (ack != 0) begin
          if (!cur_vld) chk("ack_unexpected", ack, 0);
          else begin
            oi = int'(cur[10:9]);
            chk("ack_owner", ack, 32'(1) << oi);
            cnt_m[oi]++;
            if (cur[8]) begin
              ptr_m = (oi + 1) % NR;
              chk("grant_release", grant, 0);
            end else begin
              chk("grant_hold", grant, 32'(1) << oi);
            end
            cur_vld = 1'b0;
          end
        end
        prev_grant = grant; prev_ack = ack; prev_dv = tx_dv;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  function automatic bit all_drained();
    for (int k = 0; k < NR; k++) if (rq_hd[k] != rq_tl[k]) return 1'b0;
    return exp_q.size() == 0 && !cur_vld && !busy && req_dv == 0;
  endfunction

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (t < 3000 && !all_drained()) begin
      tick();
      t++;
    end
    chk({"drain_", name}, 32'(t < 3000), 1);
  endtask

  task automatic chk_log(input string name, input logic [31:0] exp_bytes, input int n);
    chk({name, "_len"}, sent_log.size(), n);
    for (int i = 0; i < n && i < sent_log.size(); i++)
      chk({name, "_order"}, sent_log[i], exp_bytes[8*(n-1-i) +: 8]);
  endtask

  initial begin
    int len, k, rounds;
    logic [7:0] seq;

    // Reset with req0 DV held. Outputs stay 0 until release; the grant follows one cycle later.
    hold_in_rst = 1'b1;
    tick(2);
    push_byte(0, 8'h96, 1'b1);
    tick(3);
    chk("t1_rst_grant", grant, 0);
    chk("t1_rst_dv", tx_dv, 0);
    rst = 1'b0;
    hold_in_rst = 1'b0;
    tick();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_idx", grant_idx, 0);
    chk("t1_no_early_dv", tx_dv, 0);
    chk("t1_busy", busy, 1);
    wait_idle("t1");

    // Three simultaneous single-byte requests are served in RR order.
    do_reset();
    sent_log.delete();
    push_byte(0, 8'hA5, 1'b1);
    push_byte(1, 8'h3C, 1'b1);
    push_byte(2, 8'hF0, 1'b1);
    wait_idle("t2");
    chk_log("t2", 32'h00A53CF0, 3);
    for (int i = 0; i < 3; i++) chk("t2_acks", cnt_m[i], 1);

    // The req1 lock holds off req0 until the last byte.
    do_reset();
    sent_log.delete();
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    tick(3);
    push_byte(0, 8'h44, 1'b1);
    wait_idle("t3");
    chk_log("t3", 32'h11223344, 4);

    // Pointer wrap: after req3 releases, req0 wins over req3.
    do_reset();
    push_byte(3, 8'h77, 1'b1);
    wait_idle("t4a");
    sent_log.delete();
    push_byte(0, 8'h10, 1'b1);
    push_byte(3, 8'h13, 1'b1);
    wait_idle("t4");
    chk_log("t4", 32'h00001013, 2);

    // Controller not ready for 20 cycles in SEND: no DV, no ack.
    do_reset();
    sent_log.delete();
    ctrl_force_low = 1'b1;
    push_byte(2, 8'h5A, 1'b1);
    tick(2);
    chk("t5_busy", busy, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_dv_stall", tx_dv, 0);
      chk("t5_ack_stall", ack, 0);
    end
    ctrl_force_low = 1'b0;
    wait_idle("t5");
    chk_log("t5", 32'h0000005A, 1);

    // Three acks to req1, then a reset in WAIT_DONE with ready high.
    do_reset();
    push_byte(1, 8'h01, 1'b0);
    push_byte(1, 8'h02, 1'b0);
    push_byte(1, 8'h03, 1'b1);
    wait_idle("t6a");
    chk("t6_model_cnt", cnt_m[1], 3);
`ifdef SPI_TX_ARB_STATS_EN
    chk("t6_cnt", byte_cnt[CW*1 +: CW], 3);
`endif
    push_byte(2, 8'hEE, 1'b1);
    rounds = 0;
    while (rounds < 50 && !tx_dv) begin
      tick();
      rounds++;
    end
    chk("t6_dv_seen", tx_dv, 1);
    ctrl_force_low = 1'b1;
    tick(8);
    chk("t6_wait_done_busy", busy, 1);
    chk("t6_no_ack_yet", ack, 0);
    rst = 1'b1;
    ctrl_force_low = 1'b0;
    tick();
    chk("t6_rst_ack", ack, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("t6_post_ack", ack, 0);
    chk("t6_post_grant", grant, 0);
    chk("t6_post_busy", busy, 0);
`ifdef SPI_TX_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk("t6_cnt_clr", byte_cnt[CW*i +: CW], 0);
`endif

    // Random traffic with random gaps and stalls.
    do_reset();
    rand_en = 1'b1;
    for (int it = 0; it < 500; it++) begin
      tick();
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, NR - 1);
        if (rq_tl[k] - rq_hd[k] < 6) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            seq = 8'($urandom);
            push_byte(k, seq, b == len - 1);
          end
        end
      end
    end
    wait_idle("rand");
    rand_en = 1'b0;
`ifdef SPI_TX_ARB_STATS_EN
    for (int i = 0; i < NR; i++) chk("rand_cnt", byte_cnt[CW*i +: CW], cnt_m[i]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end
endmodule
